// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - writeback arbiter state type and register-address compare helpers
package ibex_pkg;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_LOAD_PEND = 1'b1
  } wb_state_e;

  localparam int unsigned RegAddrW = 5;

  // RV32E only has 16 registers, so the top address bit is ignored in every compare.
  function automatic logic addr_eq(input logic [RegAddrW-1:0] a,
                                   input logic [RegAddrW-1:0] b,
                                   input bit                  rv32e);
    return rv32e ? (a[3:0] == b[3:0]) : (a == b);
  endfunction

  function automatic logic addr_nz(input logic [RegAddrW-1:0] a,
                                   input bit                  rv32e);
    return rv32e ? (a[3:0] != 4'd0) : (a != '0);
  endfunction

endpackage

// File: rtl/ibex_wb_hold_buf.sv
// rtl/ibex_wb_hold_buf.sv - single-entry buffer for an execute result displaced by a load response
module ibex_wb_hold_buf #(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  input  logic [4:0]           addr_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 drain_i,
  output logic                 valid_o,
  output logic [4:0]           addr_o,
  output logic [DataWidth-1:0] data_o
);

  logic                 valid_q, valid_d;
  logic [4:0]           addr_q, addr_d;
  logic [DataWidth-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (valid_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      data_d  = data_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/ibex_wb_arbiter.sv
// rtl/ibex_wb_arbiter.sv - register-file writeback arbiter between execute results and load responses
// Optional collision counter enabled by defining IBEX_WB_PERF_EN.
module ibex_wb_arbiter #(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_valid_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_ready_o,
  input  logic                 lsu_req_i,
  input  logic [4:0]           lsu_req_waddr_i,
  input  logic                 lsu_rvalid_i,
  input  logic [DataWidth-1:0] lsu_rdata_i,
  input  logic                 lsu_err_i,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 hazard_a_o,
  output logic                 hazard_b_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic [31:0]          collide_cnt_o
);

  import ibex_pkg::*;

  wb_state_e            state_q, state_d;
  logic [4:0]           load_addr_q, load_addr_d;
  logic                 buf_valid, buf_load, buf_drain;
  logic [4:0]           buf_addr;
  logic [DataWidth-1:0] buf_data;
  logic                 load_resp, ex_hs;
  logic                 wr_en;
  logic [4:0]           wr_addr;
  logic [DataWidth-1:0] wr_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= WB_IDLE;
      load_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
    end
  end

  // Only one load may be outstanding, so a request while pending is dropped.
  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    case (state_q)
      WB_IDLE: begin
        if (lsu_req_i) begin
          state_d     = WB_LOAD_PEND;
          load_addr_d = lsu_req_waddr_i;
        end
      end
      WB_LOAD_PEND: begin
        if (lsu_rvalid_i) begin
          state_d = WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  assign ex_ready_o = ~buf_valid;

  always_comb begin
    load_resp = (state_q == WB_LOAD_PEND) & lsu_rvalid_i;
    ex_hs     = ex_valid_i & ex_ready_o;
    buf_load  = ex_hs & lsu_rvalid_i;
    buf_drain = buf_valid & ~lsu_rvalid_i;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    // Load response owns the write port; displaced execute results wait in the buffer.
    if (load_resp) begin
      wr_en   = ~lsu_err_i;
      wr_addr = load_addr_q;
      wr_data = lsu_rdata_i;
    end else if (buf_drain) begin
      wr_en   = 1'b1;
      wr_addr = buf_addr;
      wr_data = buf_data;
    end else if (ex_hs && !lsu_rvalid_i) begin
      wr_en   = 1'b1;
      wr_addr = ex_waddr_i;
      wr_data = ex_wdata_i;
    end
    rf_we_o    = wr_en & addr_nz(wr_addr, RV32E);
    rf_waddr_o = rf_we_o ? wr_addr : '0;
    rf_wdata_o = rf_we_o ? wr_data : '0;
    hazard_a_o = addr_nz(raddr_a_i, RV32E) &
                 (((state_q == WB_LOAD_PEND) & addr_eq(raddr_a_i, load_addr_q, RV32E)) |
                  (buf_valid & addr_eq(raddr_a_i, buf_addr, RV32E)));
    hazard_b_o = addr_nz(raddr_b_i, RV32E) &
                 (((state_q == WB_LOAD_PEND) & addr_eq(raddr_b_i, load_addr_q, RV32E)) |
                  (buf_valid & addr_eq(raddr_b_i, buf_addr, RV32E)));
  end

  ibex_wb_hold_buf #(
    .DataWidth(DataWidth)
  ) u_hold_buf (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .valid_i(buf_load),
    .addr_i (ex_waddr_i),
    .data_i (ex_wdata_i),
    .drain_i(buf_drain),
    .valid_o(buf_valid),
    .addr_o (buf_addr),
    .data_o (buf_data)
  );

`ifdef IBEX_WB_PERF_EN
  logic [31:0] collide_cnt_q, collide_cnt_d;

  always_comb begin
    collide_cnt_d = collide_cnt_q + {31'd0, ex_valid_i & lsu_rvalid_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      collide_cnt_q <= '0;
    end else begin
      collide_cnt_q <= collide_cnt_d;
    end
  end

  assign collide_cnt_o = collide_cnt_q;
`else
  assign collide_cnt_o = '0;
`endif

endmodule
